fetch_controller: RTL

Sequencing controller for the instruction-fetch stage of the chronosCore pipeline.
- Owns the fetch handshake with instruction memory.
- Drives the PC mux select, the PC write enable, the IF kill and the IF/EX register enable.
- Arbitrates between sequential fetch, predicted-taken redirect and EX-stage misprediction recovery.
- Holds one fetched instruction in a skid buffer while EX is stalled.
- Sits between imem, the hybrid branch predictor and the IF/EX boundary.

---
 rtl/fetch_controller_pkg.sv | 25 ++
 rtl/fetch_skid_buf.sv | 26 ++
 rtl/fetch_controller.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared encodings for the instruction-fetch sequencing controller.
package fetch_controller_pkg;

  typedef enum logic [1:0] {
    PCMUX_CURR_PC4 = 2'd0,
    PCMUX_BRANCH   = 2'd1,
    PCMUX_CORR_PC4 = 2'd2,
    PCMUX_PRED_TGT = 2'd3
  } pc_sel_e;

  typedef enum logic [2:0] {
    FC_BOOT  = 3'd0,
    FC_FETCH = 3'd1,
    FC_WAIT  = 3'd2,
    FC_HELD  = 3'd3,
    FC_DROP  = 3'd4
  } fc_state_e;

  localparam logic [31:0] INST_NOP = 32'h00000013;

  function automatic pc_sel_e adv_sel(input logic taken);
    return taken ? PCMUX_PRED_TGT : PCMUX_CURR_PC4;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched word and its prediction while EX stalls.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] d_inst,
  input  logic        d_pred,
  output logic        valid,
  output logic [31:0] q_inst,
  output logic        q_pred
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid  <= 1'b0;
      q_inst <= '0;
      q_pred <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      q_inst <= d_inst;
      q_pred <= d_pred;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// IF-stage sequencer: imem handshake, PC mux control, redirect recovery and skid hold.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter logic [31:0] NOP   = INST_NOP
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_val,
  input  logic             imem_req_rdy,
  input  logic             imem_resp_val,
  input  logic [31:0]      imem_resp_data,
  input  logic             pred_hit,
  input  logic             pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_br_taken,
  input  logic             ex_pred_taken,
  input  logic             ex_stall,
  output logic [1:0]       pc_sel,
  output logic             pc_en,
  output logic             kill_IF,
  output logic             ifex_en,
  output logic [31:0]      if_inst,
  output logic             if_pred_taken,
  output logic             upd_val,
  output logic             upd_taken,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  fc_state_e   state, state_n;
  pc_sel_e     sel;
  logic        resolved, mispredict, resp_pred;
  logic        skid_load, skid_clr, skid_valid, skid_pred;
  logic [31:0] skid_inst;

  assign resolved   = ex_valid & ex_is_branch & ~ex_stall;
  assign mispredict = resolved & (ex_br_taken != ex_pred_taken);
  assign resp_pred  = pred_hit & pred_taken;
  assign upd_val    = resolved;
  assign upd_taken  = ex_br_taken;
  assign pc_sel     = sel;

  fetch_skid_buf u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .clear  (skid_clr),
    .d_inst (imem_resp_data),
    .d_pred (resp_pred),
    .valid  (skid_valid),
    .q_inst (skid_inst),
    .q_pred (skid_pred)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FC_BOOT;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    imem_req_val  = 1'b0;
    sel           = PCMUX_CURR_PC4;
    pc_en         = 1'b0;
    kill_IF       = 1'b1;
    ifex_en       = 1'b0;
    if_inst       = NOP;
    if_pred_taken = 1'b0;
    skid_load     = 1'b0;
    skid_clr      = 1'b0;
    if (state == FC_BOOT) begin
      state_n = FC_FETCH;
    end else if (mispredict) begin
      sel      = ex_br_taken ? PCMUX_BRANCH : PCMUX_CORR_PC4;
      pc_en    = 1'b1;
      ifex_en  = 1'b1;
      skid_clr = 1'b1;
      // A request still in flight must be drained before fetching again.
      if ((state == FC_WAIT || state == FC_DROP) && !imem_resp_val) state_n = FC_DROP;
      else                                                          state_n = FC_FETCH;
    end else begin
      case (state)
        FC_FETCH: begin
          imem_req_val = 1'b1;
          if (imem_req_rdy) state_n = FC_WAIT;
        end
        FC_WAIT: begin
          if (imem_resp_val) begin
            if_inst       = imem_resp_data;
            if_pred_taken = resp_pred;
            kill_IF       = 1'b0;
            if (!ex_stall) begin
              ifex_en = 1'b1;
              pc_en   = 1'b1;
              sel     = adv_sel(resp_pred);
              state_n = FC_FETCH;
            end else begin
              skid_load = 1'b1;
              state_n   = FC_HELD;
            end
          end
        end
        FC_HELD: begin
          if (skid_valid) begin
            if_inst       = skid_inst;
            if_pred_taken = skid_pred;
            kill_IF       = 1'b0;
          end
          if (!ex_stall) begin
            ifex_en  = 1'b1;
            pc_en    = 1'b1;
            sel      = adv_sel(skid_pred);
            skid_clr = 1'b1;
            state_n  = FC_FETCH;
          end
        end
        FC_DROP: begin
          if (imem_resp_val) state_n = FC_FETCH;
        end
        default: state_n = FC_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (resolved && branch_cnt != '1)    branch_cnt  <= branch_cnt + CNT_W'(1);
      if (mispredict && mispred_cnt != '1) mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule
